servo_pwm_capture: RTL and testbench

Measures the ON period and full period of an incoming servo PWM signal, producing the numeric pulse width the controller's counter/comparator path would have needed to generate it. Sits at the input side of the servo subsystem: feedback and loopback checks of generated channels, and decoding of external RC-receiver pulses. Counts in prescaler ticks so results share units and width with the controller's period counter.

---
 rtl/servo_pkg.sv | 13 +
 rtl/pwm_edge_detector.sv | 36 +++
 rtl/servo_pwm_capture.sv | 120 ++++++++++++
 tb/tb_servo_pwm_capture.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo subsystem widths and capture FSM state type
package servo_pkg;

  localparam int NUMBER_WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH_COUNT,
    LOW_COUNT
  } capture_state_t;

endpackage

// File: rtl/pwm_edge_detector.sv
// rtl/pwm_edge_detector.sv - input synchronizer with rise/fall strobes
module pwm_edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pwm,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;

  // fill_q marks when level carries a real post-reset sample rather than the reset zero
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
  assign ready = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/servo_pwm_capture.sv
// rtl/servo_pwm_capture.sv - measures ON time and period of a servo PWM input in prescaler ticks
module servo_pwm_capture #(
  parameter int NUMBER_WIDTH  = servo_pkg::NUMBER_WIDTH_DEFAULT,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic                    CLOCK,
  input  logic                    RESET_N,
  input  logic                    TICK,
  input  logic                    PWM_IN,
  output logic [NUMBER_WIDTH-1:0] ON_PERIOD,
  output logic [NUMBER_WIDTH-1:0] PERIOD,
  output logic                    DATA_VALID,
  output logic                    SIGNAL_LOST,
  output logic                    OVERFLOW
);

  import servo_pkg::*;

  localparam logic [NUMBER_WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [NUMBER_WIDTH-1:0] ONE       = NUMBER_WIDTH'(1);
  localparam logic [NUMBER_WIDTH-1:0] TIMEOUT   = NUMBER_WIDTH'(TIMEOUT_TICKS);

  logic level, rise, fall, ready;

  pwm_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clock  (CLOCK),
    .reset_n(RESET_N),
    .pwm    (PWM_IN),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .ready  (ready)
  );

  capture_state_t            state;
  logic [NUMBER_WIDTH-1:0]   high_cnt, low_cnt;
  logic                      high_sat, low_sat;
  logic [NUMBER_WIDTH-1:0]   high_inc, low_inc, tick_load;
  logic [NUMBER_WIDTH:0]     sum;

  assign high_inc  = (high_cnt == MAX_COUNT) ? MAX_COUNT : high_cnt + ONE;
  assign low_inc   = (low_cnt == MAX_COUNT) ? MAX_COUNT : low_cnt + ONE;
  assign tick_load = {{(NUMBER_WIDTH-1){1'b0}}, TICK};
  assign sum       = {1'b0, high_cnt} + {1'b0, low_cnt};

  // high_cnt doubles as the WAIT_RISE timeout counter; edges always take priority over timeout
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state       <= IDLE;
      high_cnt    <= '0;
      low_cnt     <= '0;
      high_sat    <= 1'b0;
      low_sat     <= 1'b0;
      ON_PERIOD   <= '0;
      PERIOD      <= '0;
      DATA_VALID  <= 1'b0;
      SIGNAL_LOST <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && !level) begin
            state    <= WAIT_RISE;
            high_cnt <= tick_load;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state    <= HIGH_COUNT;
            high_cnt <= tick_load;
            high_sat <= 1'b0;
          end else if (TICK) begin
            high_cnt <= high_inc;
            if (high_inc == TIMEOUT) begin
              SIGNAL_LOST <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        HIGH_COUNT: begin
          if (fall) begin
            state   <= LOW_COUNT;
            low_cnt <= tick_load;
            low_sat <= 1'b0;
          end else if (TICK) begin
            high_cnt <= high_inc;
            if (high_inc == MAX_COUNT) high_sat <= 1'b1;
            if (high_inc == TIMEOUT) begin
              SIGNAL_LOST <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        LOW_COUNT: begin
          if (rise) begin
            ON_PERIOD   <= high_cnt;
            PERIOD      <= sum[NUMBER_WIDTH] ? MAX_COUNT : sum[NUMBER_WIDTH-1:0];
            OVERFLOW    <= high_sat | low_sat | sum[NUMBER_WIDTH];
            DATA_VALID  <= 1'b1;
            SIGNAL_LOST <= 1'b0;
            state       <= HIGH_COUNT;
            high_cnt    <= tick_load;
            high_sat    <= 1'b0;
          end else if (TICK) begin
            low_cnt <= low_inc;
            if (low_inc == MAX_COUNT) low_sat <= 1'b1;
            if (low_inc == TIMEOUT) begin
              SIGNAL_LOST <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb/tb_servo_pwm_capture.sv - self-checking bench for servo_pwm_capture
module tb_servo_pwm_capture;

  localparam int W = 12;
  localparam int S = 2;
  localparam int MAXV = 4095;

  logic clk = 1'b0;
  logic resetn, tick, pwm;
  logic [W-1:0] on_a, per_a, on_b, per_b;
  logic dv_a, lost_a, ov_a, dv_b, lost_b, ov_b;

  servo_pwm_capture #(.NUMBER_WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_TICKS(4000)) dut_a (
    .CLOCK(clk), .RESET_N(resetn), .TICK(tick), .PWM_IN(pwm),
    .ON_PERIOD(on_a), .PERIOD(per_a), .DATA_VALID(dv_a), .SIGNAL_LOST(lost_a), .OVERFLOW(ov_a)
  );

  servo_pwm_capture #(.NUMBER_WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_TICKS(4095)) dut_b (
    .CLOCK(clk), .RESET_N(resetn), .TICK(tick), .PWM_IN(pwm),
    .ON_PERIOD(on_b), .PERIOD(per_b), .DATA_VALID(dv_b), .SIGNAL_LOST(lost_b), .OVERFLOW(ov_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ecount = 0;
  int tick_div = 1;
  bit started = 1'b0;

  // Model: timestamps in ticks; a phase length is the ticks seen from its starting edge up to
  // (not including) its ending edge, since an edge-cycle tick belongs to the new phase.
  logic [S:0] hist;
  int nsamp, tc;
  int m_mode[2], m_start[2], m_hlen[2];
  int e_on[2], e_per[2];
  bit e_dv[2], e_lost[2], e_ov[2];

  always @(posedge clk) begin
    started = 1'b1;
    if (!resetn) begin
      hist = '0; nsamp = 0; tc = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_start[i] = 0; m_hlen[i] = 0;
        e_on[i] = 0; e_per[i] = 0; e_dv[i] = 0; e_lost[i] = 0; e_ov[i] = 0;
      end
    end else begin
      bit s, p, real_s, r, f;
      s = hist[S-1];
      p = hist[S];
      real_s = (nsamp >= S);
      r = s && !p;
      f = !s && p;
      for (int i = 0; i < 2; i++) begin
        int tmo, llen;
        bit tmo_hit;
        tmo = (i == 0) ? 4000 : 4095;
        tmo_hit = tick && (tc + 1 - m_start[i] == tmo);
        e_dv[i] = 0;
        case (m_mode[i])
          0: if (real_s && !s) begin m_mode[i] = 1; m_start[i] = tc; end
          1: if (r) begin m_mode[i] = 2; m_start[i] = tc; end
             else if (tmo_hit) begin e_lost[i] = 1; m_mode[i] = 0; end
          2: if (f) begin m_hlen[i] = tc - m_start[i]; m_mode[i] = 3; m_start[i] = tc; end
             else if (tmo_hit) begin e_lost[i] = 1; m_mode[i] = 0; end
          default: if (r) begin
               llen = tc - m_start[i];
               e_on[i] = (m_hlen[i] > MAXV) ? MAXV : m_hlen[i];
               e_per[i] = (m_hlen[i] + llen > MAXV) ? MAXV : m_hlen[i] + llen;
               e_ov[i] = (m_hlen[i] >= MAXV) || (llen >= MAXV) || (m_hlen[i] + llen > MAXV);
               e_dv[i] = 1; e_lost[i] = 0;
               m_mode[i] = 2; m_start[i] = tc;
             end else if (tmo_hit) begin e_lost[i] = 1; m_mode[i] = 0; end
        endcase
      end
      tc = tc + int'(tick);
      hist = {hist[S-1:0], pwm};
      nsamp++;
    end
  end

  task automatic cmp_cycle(int i, logic [W-1:0] on, logic [W-1:0] per, logic dv, logic lost, logic ov);
    tests++;
    if ({on, per, dv, lost, ov} !== {W'(e_on[i]), W'(e_per[i]), e_dv[i], e_lost[i], e_ov[i]}) begin
      fails++;
      $display("FAIL cycle_model[%0d] t=%0t on/per/dv/lost/ov got %0d/%0d/%0b/%0b/%0b expected %0d/%0d/%0b/%0b/%0b",
               i, $time, on, per, dv, lost, ov, e_on[i], e_per[i], e_dv[i], e_lost[i], e_ov[i]);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_cycle(0, on_a, per_a, dv_a, lost_a, ov_a);
      cmp_cycle(1, on_b, per_b, dv_b, lost_b, ov_b);
    end
  end

  int q_on[$], q_per[$], q_ov[$];
  always @(negedge clk) begin
    if (dv_a) begin
      q_on.push_back(int'(on_a));
      q_per.push_back(int'(per_a));
      q_ov.push_back(int'(ov_a));
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic adv(int n);
    repeat (n) begin
      @(negedge clk);
      ecount++;
      tick = (tick_div == 1) ? 1'b1 : ((ecount % tick_div) == 0);
    end
  endtask

  task automatic clear_q();
    q_on.delete(); q_per.delete(); q_ov.delete();
  endtask

  task automatic chk_entry(string name, int idx, int on, int per, int ov);
    if (q_on.size() > idx) begin
      chk({name, "_on"}, q_on[idx], on);
      chk({name, "_per"}, q_per[idx], per);
      chk({name, "_ov"}, q_ov[idx], ov);
    end else begin
      chk({name, "_present"}, q_on.size(), idx + 1);
    end
  endtask

  initial begin
    resetn = 1'b0; pwm = 1'b1; tick = 1'b1;
    adv(3);
    chk("reset_on", int'(on_a), 0);
    chk("reset_per", int'(per_a), 0);
    chk("reset_flags", int'({dv_a, lost_a, ov_a}), 0);

    // start-up with PWM high: partial pulse discarded
    resetn = 1'b1;
    adv(200);
    pwm = 1'b0; adv(500);
    chk("partial_no_dv", q_on.size(), 0);

    // 300/2700 ticks, three periods
    for (int k = 0; k < 3; k++) begin
      pwm = 1'b1; adv(300);
      pwm = 1'b0; adv(2700);
      if (k == 0) chk("first_period_no_dv", q_on.size(), 0);
    end
    pwm = 1'b1; adv(5);
    chk("three_dv", q_on.size(), 3);
    for (int k = 0; k < 3; k++) chk_entry("period", k, 300, 3000, 0);
    clear_q();

    // low too long: signal lost, outputs hold
    adv(295);
    pwm = 1'b0; adv(4100);
    chk("lost_a", int'(lost_a), 1);
    chk("lost_b", int'(lost_b), 1);
    chk("lost_hold_on", int'(on_a), 300);
    chk("lost_hold_per", int'(per_a), 3000);
    chk("lost_no_dv", q_on.size(), 0);
    pwm = 1'b1; adv(300);
    pwm = 1'b0; adv(2700);
    chk("lost_still_set", int'(lost_a), 1);
    pwm = 1'b1; adv(5);
    chk("recover_dv", q_on.size(), 1);
    chk_entry("recover", 0, 300, 3000, 0);
    chk("lost_cleared", int'(lost_a), 0);
    clear_q();

    // 3000 high / 1500 low: period saturates
    adv(2995);
    pwm = 1'b0; adv(1500);
    pwm = 1'b1; adv(5);
    chk_entry("sat_a", 0, 3000, 4095, 1);
    chk("sat_b_on", int'(on_b), 3000);
    chk("sat_b_per", int'(per_b), 4095);
    chk("sat_b_ov", int'(ov_b), 1);
    clear_q();

    // tick every 4th clock, edges aligned with tick cycles
    pwm = 1'b0; adv(100);
    tick_div = 4;
    while ((ecount % 4) != 2) adv(1);
    for (int k = 0; k < 2; k++) begin
      pwm = 1'b1; adv(160);
      pwm = 1'b0; adv(240);
    end
    pwm = 1'b1; adv(8);
    chk("div4_dv", q_on.size(), 3);
    chk_entry("div4_a", 1, 40, 100, 0);
    chk_entry("div4_b", 2, 40, 100, 0);
    clear_q();

    // reset mid HIGH_COUNT
    tick_div = 1;
    adv(100);
    resetn = 1'b0; adv(1);
    chk("midreset_on", int'(on_a), 0);
    chk("midreset_per", int'(per_a), 0);
    chk("midreset_flags", int'({dv_a, lost_a, ov_a}), 0);
    resetn = 1'b1;
    adv(200);
    pwm = 1'b0; adv(500);
    pwm = 1'b1; adv(250);
    pwm = 1'b0; adv(750);
    pwm = 1'b1; adv(5);
    chk("midreset_dv", q_on.size(), 1);
    chk_entry("midreset", 0, 250, 1000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
